fetch_pc_ctrl: RTL
==================

// Module: fetch_pc_ctrl
// PURPOSE
//  F-stage PC sequencer for the P6 pipeline: owns the fetch PC register, drives a req/ready/rvalid
//  instruction-memory handshake, holds the fetched word for the F/D register and applies D-stage
//  jump/branch redirects from NPC with MIPS delay-slot semantics. Sits between hazard unit, NPC and IM.
// PARAMETERS
//  RESET_PC    32'h0000_3000  PC loaded on reset
//  EXC_VECTOR  32'h0000_4180  handler entry (FETCH_EXC_EN only)
// PORTS
//  clk              in   1   clock, rising edge
//  reset            in   1   asynchronous, active-high
//  D_stall          in   1   hazard stall; 1 = D does not accept F word this cycle
//  D_redirect_valid in   1   one-cycle pulse: taken branch/jump/jr leaving D (already qualified by !D_stall)
//  D_redirect_pc    in   32  redirect target (NPC result)
//  imem_req         out  1   fetch request
//  imem_addr        out  32  fetch address (= F_pc)
//  imem_ready       in   1   IM accepts request this cycle
//  imem_rvalid      in   1   read data valid (earliest cycle after accept)
//  imem_rdata       in   32  instruction word
//  F_valid          out  1   F_instr/F_pc hold a valid fetched instruction
//  F_pc             out  32  PC of current fetch / held word
//  F_instr          out  32  held instruction word
// BEHAVIOUR
//  Reset (async): state=S_IDLE, F_pc=RESET_PC, F_instr=0, F_valid=0, imem_req=0, redir_pend=0.
//  FSM: S_IDLE -> S_REQ (one cycle after reset release).
//   S_REQ : imem_req=1; imem_ready -> S_WAIT, else stay (addr stable while req high).
//   S_WAIT: imem_rvalid -> capture rdata into F_instr, F_valid=1, -> S_HOLD. rvalid ignored in other states.
//   S_HOLD: F_valid=1; D_stall -> stay (F_pc/F_instr frozen); !D_stall = consume: F_valid<=0,
//           F_pc<=pc_next, -> S_REQ. Min issue interval 3 cycles/instruction.
//  pc_next = D_redirect_valid ? D_redirect_pc : redir_pend ? redir_pc : F_pc+32'd4 (mod 2^32, wraps).
//  Delay slot: redirect arriving while F is in S_REQ/S_WAIT (delay slot not yet fetched) latches
//   redir_pc/redir_pend=1; delay slot completes normally, target applied on its consume; pend cleared on consume.
//  Redirect in same cycle as consume in S_HOLD: applied directly, pend not set.
//  Redirect while redir_pend=1: newer target overwrites (branch in delay slot is architecturally undefined).
//  No speculative fetch: only one request outstanding; F_pc never changes while imem_req=1.
//  Reset mid-fetch: state and outputs return to reset values immediately; a late rvalid is ignored.
// CONFIGURATION
//  FETCH_EXC_EN defined: adds ports exc_req in 1, eret_req in 1, epc in 32, F_exc_adel out 1.
//   exc_req (priority over eret) / eret_req: flush; redir_pend<=0, F_valid<=0; F_pc<=EXC_VECTOR / epc.
//   If in S_WAIT, enter S_DRAIN: wait rvalid, discard data, -> S_REQ; else -> S_REQ next cycle.
//   Misaligned F_pc (F_pc[1:0]!=0): no imem request; go straight to S_HOLD with F_instr=0,
//   F_exc_adel=1 (cleared on consume/flush); reset value F_exc_adel=0.
//  Not defined: ports absent, no flush/drain, misaligned PC fetched with imem_addr=F_pc unchanged.
// TESTING
//  Reset release, ready=1, rvalid 1 cycle later, no stall -> imem_addr 3000,3004,3008 every 3 cycles.
//  D_stall=1 for 5 cycles in S_HOLD at F_pc=300C -> F_pc/F_instr/F_valid frozen, no imem_req.
//  Consume of 3004 with redirect to 3040 -> next imem_addr=3040; F_pc never shows 3008.
//  Redirect 3100 while 3008 in S_WAIT (ready held 0 first 2 cycles) -> 3008 delivered, then 3100.
//  Assert reset during S_WAIT, rvalid one cycle after release -> F_valid stays 0, fetch restarts at 3000.
//  (FETCH_EXC_EN) exc_req during S_WAIT -> stale rvalid discarded, next imem_addr=4180; eret epc=3202 -> F_exc_adel=1, F_instr=0, no imem_req.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: F-stage PC sequencer with IM req/ready/rvalid handshake and delay-slot redirects.
// Define FETCH_EXC_EN for exception/eret flush, stale-read drain and misaligned-PC AdEL reporting.
module fetch_pc_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000
`ifdef FETCH_EXC_EN
 , parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        D_stall,
   input  logic        D_redirect_valid,
   input  logic [31:0] D_redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
`ifdef FETCH_EXC_EN
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic        F_exc_adel,
`endif
   output logic        F_valid,
   output logic [31:0] F_pc,
   output logic [31:0] F_instr
);
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_d, redir_pc_q, redir_pc_d, pc_next;
   logic        valid_q, valid_d, redir_pend_q, redir_pend_d, consume;
`ifdef FETCH_EXC_EN
   logic        adel_q, adel_d, misal;
   assign misal = |pc_q[1:0];
`endif
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         instr_q      <= '0;
         valid_q      <= 1'b0;
         redir_pend_q <= 1'b0;
         redir_pc_q   <= '0;
`ifdef FETCH_EXC_EN
         adel_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         valid_q      <= valid_d;
         redir_pend_q <= redir_pend_d;
         redir_pc_q   <= redir_pc_d;
`ifdef FETCH_EXC_EN
         adel_q       <= adel_d;
`endif
      end
   end
   always_comb begin
      consume      = state_q == S_HOLD && !D_stall;
      pc_next      = D_redirect_valid ? D_redirect_pc : redir_pend_q ? redir_pc_q : pc_q + 32'd4;
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      valid_d      = valid_q;
      redir_pend_d = redir_pend_q;
      redir_pc_d   = redir_pc_q;
`ifdef FETCH_EXC_EN
      adel_d       = adel_q;
`endif
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
`ifdef FETCH_EXC_EN
            if (misal) begin
               state_d = S_HOLD;
               instr_d = '0;
               valid_d = 1'b1;
               adel_d  = 1'b1;
            end else
`endif
            if (imem_ready) state_d = S_WAIT;
         end
         S_WAIT: if (imem_rvalid) begin
            state_d = S_HOLD;
            instr_d = imem_rdata;
            valid_d = 1'b1;
         end
         S_HOLD: if (!D_stall) begin
            state_d = S_REQ;
            valid_d = 1'b0;
            pc_d    = pc_next;
         end
         S_DRAIN: if (imem_rvalid) state_d = S_REQ;
         default: state_d = S_IDLE;
      endcase
      // Redirect before the delay slot is consumed waits until that slot leaves F
      if (D_redirect_valid && !consume) begin
         redir_pend_d = 1'b1;
         redir_pc_d   = D_redirect_pc;
      end
      if (consume) redir_pend_d = 1'b0;
`ifdef FETCH_EXC_EN
      if (consume) adel_d = 1'b0;
      if (exc_req || eret_req) begin
         pc_d         = exc_req ? EXC_VECTOR : epc;
         redir_pend_d = 1'b0;
         valid_d      = 1'b0;
         adel_d       = 1'b0;
         state_d      = (state_q == S_WAIT || state_q == S_DRAIN) && !imem_rvalid ? S_DRAIN : S_REQ;
      end
`endif
   end
   always_comb begin
`ifdef FETCH_EXC_EN
      imem_req   = state_q == S_REQ && !misal;
      F_exc_adel = adel_q;
`else
      imem_req   = state_q == S_REQ;
`endif
      imem_addr  = pc_q;
      F_valid    = valid_q;
      F_pc       = pc_q;
      F_instr    = instr_q;
   end
endmodule
